// File: rtl/packet_checker_64.sv
// AXI4-Stream sink that checks the 64-bit counter-pattern stream and keeps
// packet, word and error statistics for register readback.
module packet_checker_64 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned PKT_WIDTH  = 10,
    parameter logic [35:0] SIG        = 36'h0_000A_0000
) (
    input  logic                  user_clk,
    input  logic                  user_rst,
    input  logic                  check_ena,
    input  logic                  clr_stats,
    input  logic [3:0]            throttle,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  locked,
    output logic [31:0]           pkt_count,
    output logic [31:0]           word_count,
    output logic [15:0]           err_count,
    output logic                  err_flag,
    output logic [63:0]           last_err_word
);

    typedef enum logic [1:0] {StIdle, StSync, StCheck, StDrain} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cyc_q;
    logic [27:0]           exp_q, exp_d;
    logic                  locked_q, locked_d;

    logic                  st_vld_q, st_err_q, st_last_q;
    logic [DATA_WIDTH-1:0] st_data_q;

    logic [31:0]           pkt_count_q, word_count_q;
    logic [15:0]           err_count_q;
    logic                  err_flag_q;
    logic [63:0]           last_err_word_q;

    logic                  accept;
    logic                  sig_ok;
    logic                  lock_hit;
    logic                  check_beat;
    logic                  beat_err;
    logic [27:0]           seq;
    logic [27:0]           exp_cur;

    assign s_axis_tready = (state_q != StIdle) && (cyc_q >= throttle);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign seq           = s_axis_tdata[27:0];
    assign sig_ok        = (s_axis_tdata[DATA_WIDTH-1:28] == SIG);
    assign lock_hit      = sig_ok && (seq[PKT_WIDTH-1:0] == '0);

    // The lock beat is checked against itself, so only keep/last can flag it.
    assign exp_cur  = (state_q == StSync) ? seq : exp_q;
    assign beat_err = !sig_ok || (seq != exp_cur) || (s_axis_tkeep != {KEEP_WIDTH{1'b1}}) ||
                      (s_axis_tlast != (&exp_cur[PKT_WIDTH-1:0]));

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        locked_d   = locked_q;
        check_beat = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (check_ena) state_d = StSync;
            end
            StSync: begin
                if (!check_ena) begin
                    state_d = StIdle;
                end else if (accept && lock_hit) begin
                    check_beat = 1'b1;
                    locked_d   = 1'b1;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                check_beat = accept;
                if (!check_ena) state_d = (accept && s_axis_tlast) ? StIdle : StDrain;
            end
            StDrain: begin
                check_beat = accept;
                if (accept && s_axis_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Good beats have seq == exp, so seq+1 covers both advance and resync.
        if (check_beat) exp_d = seq + 28'd1;
        if (state_d == StIdle) locked_d = 1'b0;
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q   <= StIdle;
            cyc_q     <= 4'd0;
            exp_q     <= 28'd0;
            locked_q  <= 1'b0;
            st_vld_q  <= 1'b0;
            st_err_q  <= 1'b0;
            st_last_q <= 1'b0;
            st_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_q + 4'd1;
            exp_q     <= exp_d;
            locked_q  <= locked_d;
            st_vld_q  <= check_beat;
            st_err_q  <= check_beat && beat_err;
            st_last_q <= check_beat && s_axis_tlast;
            st_data_q <= s_axis_tdata;
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst || clr_stats) begin
            pkt_count_q     <= 32'd0;
            word_count_q    <= 32'd0;
            err_count_q     <= 16'd0;
            err_flag_q      <= 1'b0;
            last_err_word_q <= 64'd0;
        end else if (st_vld_q) begin
            word_count_q <= word_count_q + 32'd1;
            if (st_last_q) pkt_count_q <= pkt_count_q + 32'd1;
            if (st_err_q) begin
                if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                err_flag_q      <= 1'b1;
                last_err_word_q <= st_data_q;
            end
        end
    end

    assign locked        = locked_q;
    assign pkt_count     = pkt_count_q;
    assign word_count    = word_count_q;
    assign err_count     = err_count_q;
    assign err_flag      = err_flag_q;
    assign last_err_word = last_err_word_q;

endmodule

// File: tb/tb_packet_checker_64.sv
// Randomized scoreboard bench for packet_checker_64: the driver queues every beat it offers,
// the monitor pops accepted beats into a behavioural model and compares all outputs each cycle.
module tb_packet_checker_64;

    localparam logic [35:0] SIG = 36'h0_000A_0000;
    localparam int M_IDLE = 0, M_SYNC = 1, M_CHECK = 2, M_DRAIN = 3;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic        check_ena = 1'b0;
    logic        clr_stats = 1'b0;
    logic [3:0]  throttle = 4'd0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = 8'hFF;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        locked;
    logic [31:0] pkt_count;
    logic [31:0] word_count;
    logic [15:0] err_count;
    logic        err_flag;
    logic [63:0] last_err_word;

    packet_checker_64 dut (
        .user_clk      (user_clk),
        .user_rst      (user_rst),
        .check_ena     (check_ena),
        .clr_stats     (clr_stats),
        .throttle      (throttle),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .locked        (locked),
        .pkt_count     (pkt_count),
        .word_count    (word_count),
        .err_count     (err_count),
        .err_flag      (err_flag),
        .last_err_word (last_err_word)
    );

    always #5 user_clk = ~user_clk;

    int    checks = 0;
    int    failures = 0;
    bit    gaps = 1'b1;
    beat_t beat_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 1'b0;
    int          m_mode, m_cyc, m_err;
    logic [27:0] m_exp;
    bit          m_locked, m_flag;
    logic [31:0] m_pkt, m_word;
    logic [63:0] m_last;
    bit          p_vld, p_last, p_err;
    logic [63:0] p_data;

    task automatic model_beat(input beat_t b, input logic [27:0] e);
        p_vld  = 1'b1;
        p_last = b.l;
        p_data = b.d;
        p_err  = (b.d[63:28] != SIG) || (b.d[27:0] != e) || (b.k != 8'hFF) ||
                 (b.l != (e % 1024 == 1023));
        m_exp  = b.d[27:0] + 28'd1;
    endtask

    always @(negedge user_clk) begin
        beat_t b;
        bit    hs, got;
        if (m_valid) begin
            chk("tready", s_axis_tready, (m_mode != M_IDLE) && (m_cyc >= int'(throttle)));
            chk("locked", locked, m_locked);
            chk("pkt_count", pkt_count, m_pkt);
            chk("word_count", word_count, m_word);
            chk("err_count", err_count, m_err);
            chk("err_flag", err_flag, m_flag);
            chk("last_err_word", last_err_word, m_last);
        end
        if (user_rst) begin
            m_valid = 1'b1;
            m_mode = M_IDLE; m_cyc = 0; m_exp = '0; m_locked = 0;
            m_pkt = 0; m_word = 0; m_err = 0; m_flag = 0; m_last = '0;
            p_vld = 0; p_last = 0; p_err = 0; p_data = '0;
            beat_q.delete();
        end else if (m_valid) begin
            hs  = s_axis_tvalid && s_axis_tready;
            got = 1'b0;
            if (hs) begin
                if (beat_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL scoreboard: beat accepted with nothing queued (t=%0t)", $time);
                end else begin
                    b = beat_q.pop_front();
                    got = 1'b1;
                end
            end
            if (clr_stats) begin
                m_pkt = 0; m_word = 0; m_err = 0; m_flag = 0; m_last = '0;
            end else if (p_vld) begin
                m_word++;
                if (p_last) m_pkt++;
                if (p_err) begin
                    if (m_err < 65535) m_err++;
                    m_flag = 1;
                    m_last = p_data;
                end
            end
            p_vld = 0;
            case (m_mode)
                M_IDLE: if (check_ena) m_mode = M_SYNC;
                M_SYNC: begin
                    if (!check_ena) m_mode = M_IDLE;
                    else if (got && b.d[63:28] == SIG && b.d[9:0] == 0) begin
                        model_beat(b, b.d[27:0]);
                        m_locked = 1;
                        m_mode = M_CHECK;
                    end
                end
                M_CHECK: begin
                    if (got) model_beat(b, m_exp);
                    if (!check_ena) m_mode = (got && b.l) ? M_IDLE : M_DRAIN;
                end
                default: begin
                    if (got) model_beat(b, m_exp);
                    if (got && b.l) m_mode = M_IDLE;
                end
            endcase
            if (m_mode == M_IDLE) m_locked = 0;
            m_cyc = (m_cyc + 1) % 16;
        end
    end

    // ---------------- driver ----------------
    function automatic logic [63:0] word(input logic [27:0] w);
        return {SIG, w};
    endfunction

    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
        int    n;
        bit    hs;
        beat_t b;
        b.d = d; b.k = k; b.l = l;
        beat_q.push_back(b);
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge user_clk);
            hs = s_axis_tready;
            @(posedge user_clk);
            #1;
            if (hs) break;
            n++;
            if (n > 400) begin
                failures++;
                $display("FAIL handshake_timeout: beat %0h never accepted", d);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "handshake timeout");
            end
        end
        s_axis_tvalid = 1'b0;
        if (gaps && $urandom_range(0, 7) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge user_clk); #1; end
    endtask

    task automatic send_word(input logic [27:0] w);
        send(word(w), 8'hFF, &w[9:0]);
    endtask

    task automatic reset_dut();
        @(posedge user_clk); #1;
        user_rst = 1'b1; s_axis_tvalid = 1'b0; clr_stats = 1'b0; check_ena = 1'b0;
        repeat (2) begin @(posedge user_clk); #1; end
        user_rst = 1'b0;
        @(negedge user_clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_word", word_count, 0);
        chk("rst_err", {err_flag, err_count}, 0);
        chk("rst_last_err", last_err_word, 0);
        @(posedge user_clk); #1;
    endtask

    task automatic settle();
        repeat (3) begin @(posedge user_clk); #1; end
        @(negedge user_clk);
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int          hi;
        logic [27:0] w;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;

        // 1: three aligned packets at full rate
        reset_dut();
        check_ena = 1'b1;
        for (int i = 0; i < 3072; i++) send_word(28'(i));
        settle();
        chk("t1_pkt", pkt_count, 3);
        chk("t1_word", word_count, 3072);
        chk("t1_err", err_count, 0);
        chk("t1_locked", locked, 1);

        // 2: mid-packet start, lock at 1024
        reset_dut();
        check_ena = 1'b1;
        for (int i = 700; i < 3072; i++) send_word(28'(i));
        settle();
        chk("t2_pkt", pkt_count, 2);
        chk("t2_word", word_count, 2048);
        chk("t2_err", err_count, 0);

        // 3: word 5 dropped
        reset_dut();
        check_ena = 1'b1;
        for (int i = 0; i < 1024; i++) if (i != 5) send_word(28'(i));
        settle();
        chk("t3_err", err_count, 1);
        chk("t3_last_err", last_err_word, 64'h0000_A000_0000_0006);
        chk("t3_flag", err_flag, 1);

        // 4: missing tlast and bad tkeep
        reset_dut();
        check_ena = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            w = 28'(i);
            send(word(w), (i == 1500) ? 8'h0F : 8'hFF, (i == 1023) ? 1'b0 : &w[9:0]);
        end
        settle();
        chk("t4_err", err_count, 2);
        chk("t4_pkt", pkt_count, 1);

        // 5: check_ena dropped mid-packet drains to the boundary
        reset_dut();
        check_ena = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            if (i == 300) check_ena = 1'b0;
            send_word(28'(i));
        end
        @(negedge user_clk);
        chk("t5_tready_after_last", s_axis_tready, 0);
        chk("t5_locked_idle", locked, 0);
        settle();
        chk("t5_word", word_count, 1024);
        chk("t5_pkt", pkt_count, 1);

        // 6: half-rate back-pressure and clr_stats
        reset_dut();
        gaps = 1'b0;
        throttle = 4'd8;
        check_ena = 1'b1;
        for (int i = 0; i < 1024; i++) send_word(28'(i));
        hi = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge user_clk);
            if (s_axis_tready) hi++;
        end
        chk("t6_duty", hi, 16);
        chk("t6_word", word_count, 1024);
        chk("t6_pkt", pkt_count, 1);
        @(posedge user_clk); #1;
        clr_stats = 1'b1;
        @(posedge user_clk); #1;
        clr_stats = 1'b0;
        @(negedge user_clk);
        chk("t6_clr_word", word_count, 0);
        chk("t6_clr_pkt", pkt_count, 0);
        chk("t6_locked_kept", locked, 1);

        // 7: random throttle, errors, a clr pulse, exp wrap, then mid-packet reset
        reset_dut();
        gaps = 1'b1;
        throttle = 4'($urandom_range(0, 7));
        check_ena = 1'b1;
        fork
            begin
                w = 28'hFFFFB00;
                for (int i = 0; i < 1700; i++) begin
                    d = word(w); k = 8'hFF; l = &w[9:0];
                    if ($urandom_range(0, 63) == 0) begin
                        case ($urandom_range(0, 3))
                            0: d[40] = ~d[40];
                            1: begin w = w + 28'd1; d = word(w); l = &w[9:0]; end
                            2: k = 8'h0F;
                            default: l = ~l;
                        endcase
                    end
                    send(d, k, l);
                    w = w + 28'd1;
                end
            end
            begin
                repeat ($urandom_range(1500, 2500)) @(posedge user_clk);
                #1;
                clr_stats = 1'b1;
                @(posedge user_clk); #1;
                clr_stats = 1'b0;
            end
        join
        settle();
        reset_dut();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
